menu_button_array: RTL and testbench
====================================

// Module: menu_button_array
// PURPOSE
// - Draws a vertical column of NUM_BUTTONS rectangular menu buttons as one VGA object.
// - Owns menu selection: Up/Down navigation with wrap-around, and Enter-triggered press-flash animation.
// - Emits a one-cycle pressed pulse with the chosen index when the flash completes.
// - Feeds the object drawing mux like every other game object: drawingRequest + RGBout + offsets.
// PARAMETERS
// - NUM_BUTTONS     4          number of buttons, 2..8
// - ORIGIN_X        260        left X of the column (pixels)
// - ORIGIN_Y        100        top Y of button 0 (pixels)
// - BUTTON_WIDTH_X  120        button width (pixels)
// - BUTTON_HEIGHT_Y 50         button height (pixels)
// - BUTTON_GAP_Y    10         vertical gap between buttons (pixels)
// - BORDER          2          border thickness (pixels), < BUTTON_HEIGHT_Y/2
// - FLASH_FRAMES    8          length of the press animation, in frames, >= 1
// - COLOR_REGU/SLCT/PRESS/BORDER  8'h80/8'h10/8'hFC/8'h00   RGB332 colours
// PORTS
// - clk             in   1             pixel clock
// - resetN          in   1             asynchronous, active-low reset
// - startOfFrame    in   1             one-cycle pulse per frame
// - pixelX          in   11            current VGA pixel X
// - pixelY          in   11            current VGA pixel Y
// - enable          in   1             menu active
// - keyUp           in   1             level key input, synchronous to clk
// - keyDown         in   1             level key input, synchronous to clk
// - keyEnter        in   1             level key input, synchronous to clk
// - drawingRequest  out  1             pixel lies inside a button
// - RGBout          out  8             pixel colour; 8'hFF = transparent
// - offsetX         out  11            pixel offset from the hit button's top-left
// - offsetY         out  11            pixel offset from the hit button's top-left
// - buttonIdx       out  IW            index of the hit button; IW = $clog2(NUM_BUTTONS)
// - selectedIdx     out  IW            currently highlighted button
// - pressedValid    out  1             one-cycle pulse when a press completes
// - pressedIdx      out  IW            index that was pressed; valid with pressedValid
// BEHAVIOUR
// - Reset values:
//   - All outputs 0, except RGBout = 8'hFF.
//   - FSM = NAV, selectedIdx = 0, frame counter = 0, key edge registers = 0.
// - Keys: each key acts only on its rising edge (registered previous level).
//   - A key held high produces exactly one event.
// - FSM NAV (only while enable = 1):
//   - Up edge: selectedIdx - 1; from 0 it wraps to NUM_BUTTONS-1.
//   - Down edge: selectedIdx + 1; from NUM_BUTTONS-1 it wraps to 0.
//   - Up and Down edges in the same cycle: no move.
//   - Enter edge: go to FLASH, clear the counter. Enter has priority over Up/Down in the same cycle.
// - FSM FLASH:
//   - Up, Down and Enter are ignored.
//   - The counter increments on each startOfFrame.
//   - On the startOfFrame where counter == FLASH_FRAMES-1: next cycle pressedValid = 1 and pressedIdx = selectedIdx; FSM returns to NAV.
// - enable = 0:
//   - FSM forced to NAV; FLASH aborts with no pulse.
//   - selectedIdx is held.
//   - Drawing outputs are forced to the outside values.
// - Drawing: fully registered, latency 1 clk from pixelX/pixelY.
//   - Button i spans X in [ORIGIN_X, ORIGIN_X+W) and Y in [ORIGIN_Y + i*(H+GAP), + H).
//   - The gap is outside every button; the regions are disjoint.
//   - Inside button i: drawingRequest = 1, buttonIdx = i, offsets = pixel - top-left.
//   - Colour inside button i, in priority order:
//     - border band (offset < BORDER or offset >= size-BORDER, either axis): COLOR_BORDER;
//     - i == selectedIdx in FLASH: COLOR_PRESS when counter[0] = 0, else COLOR_SLCT;
//     - i == selectedIdx: COLOR_SLCT;
//     - otherwise: COLOR_REGU.
//   - Outside all buttons: RGBout = 8'hFF, drawingRequest = 0, offsets = 0, buttonIdx = 0.
// - Arithmetic:
//   - Geometry is computed unsigned on 12 bits, so pixel 2047 never wraps into a hit.
//   - Elaboration error if ORIGIN_Y + NUM_BUTTONS*(H+GAP) > 480 or ORIGIN_X + W > 640.
// - Reset mid-FLASH: immediate return to NAV, selection 0, no pulse.
// STRUCTURE
// - menu_pkg: RGB332 colour constants, TRANSPARENT_ENCODING = 8'hFF, menu_state_t enum {NAV, FLASH}.
// - Sub-module key_edge_detect: parametrised width, registered rising-edge pulse per bit.
//   - One instance, width 3, covering Up/Down/Enter.
// - The hit test is a generate loop over NUM_BUTTONS comparators; a priority encoder selects the index.
// TESTING
// - Reset, then sweep pixel (300,130) -> one cycle later: drawingRequest=1, buttonIdx=0, RGBout=COLOR_SLCT, offsets (40,30).
// - Pixel (300,155) (gap) -> drawingRequest=0, RGBout=8'hFF. Pixel (260,100) -> RGBout=COLOR_BORDER.
// - Up pulse at selectedIdx 0 -> selectedIdx = 3. Down pulse at 3 -> 0. Up+Down together -> no change.
// - keyDown held high for 100 cycles -> selectedIdx advances exactly once.
// - Enter at selectedIdx 2, then 8 startOfFrame pulses -> fill toggles PRESS/SLCT per frame.
//   - Exactly one pressedValid with pressedIdx = 2; Up during the flash is ignored.
// - Enter, then enable=0 after 3 frames -> no pressedValid, FSM in NAV, selectedIdx unchanged. Assert resetN mid-FLASH -> selectedIdx=0, no pulse.

Source files
------------

// File: rtl/menu_button_array_pkg.sv
// Shared colour constants, FSM state type and a span-test helper for the menu button column.
package menu_pkg;

    localparam logic [7:0] COL_REGU             = 8'h80;
    localparam logic [7:0] COL_SLCT             = 8'h10;
    localparam logic [7:0] COL_PRESS            = 8'hFC;
    localparam logic [7:0] COL_BORDER           = 8'h00;
    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    typedef enum logic {
        NAV   = 1'b0,
        FLASH = 1'b1
    } menu_state_t;

    // Half-open interval test [lo, lo+len) on 12-bit unsigned values.
    function automatic logic in_span(input logic [11:0] v, input logic [11:0] lo,
                                     input logic [11:0] len);
        return (v >= lo) && (v < (lo + len));
    endfunction

endpackage

// File: rtl/menu_button_array_key_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse per bit on each 0->1 transition.
module key_edge_detect #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev_r;

    // Remember the previous level and emit the registered rising-edge pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prev_r <= '0;
            rise   <= '0;
        end else begin
            prev_r <= level;
            rise   <= level & ~prev_r;
        end
    end

endmodule

// File: rtl/menu_button_array.sv
// Vertical column of menu buttons drawn as one VGA object, with Up/Down selection
// and an Enter-triggered press-flash that ends in a one-cycle pressed pulse.
module menu_button_array
    import menu_pkg::*;
#(
    parameter int         NUM_BUTTONS     = 4,
    parameter int         ORIGIN_X        = 260,
    parameter int         ORIGIN_Y        = 100,
    parameter int         BUTTON_WIDTH_X  = 120,
    parameter int         BUTTON_HEIGHT_Y = 50,
    parameter int         BUTTON_GAP_Y    = 10,
    parameter int         BORDER          = 2,
    parameter int         FLASH_FRAMES    = 8,
    parameter logic [7:0] COLOR_REGU      = COL_REGU,
    parameter logic [7:0] COLOR_SLCT      = COL_SLCT,
    parameter logic [7:0] COLOR_PRESS     = COL_PRESS,
    parameter logic [7:0] COLOR_BORDER    = COL_BORDER,
    localparam int        IW              = $clog2(NUM_BUTTONS)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          startOfFrame,
    input  logic [10:0]   pixelX,
    input  logic [10:0]   pixelY,
    input  logic          enable,
    input  logic          keyUp,
    input  logic          keyDown,
    input  logic          keyEnter,
    output logic          drawingRequest,
    output logic [7:0]    RGBout,
    output logic [10:0]   offsetX,
    output logic [10:0]   offsetY,
    output logic [IW-1:0] buttonIdx,
    output logic [IW-1:0] selectedIdx,
    output logic          pressedValid,
    output logic [IW-1:0] pressedIdx
);

    localparam int PITCH = BUTTON_HEIGHT_Y + BUTTON_GAP_Y;
    localparam int CW    = $clog2(FLASH_FRAMES + 1);

    if (NUM_BUTTONS < 2 || NUM_BUTTONS > 8) begin : g_bad_count
        $error("menu_button_array: NUM_BUTTONS must be 2..8");
    end
    if (ORIGIN_Y + NUM_BUTTONS * PITCH > 480 || ORIGIN_X + BUTTON_WIDTH_X > 640) begin : g_bad_fit
        $error("menu_button_array: button column does not fit in 640x480");
    end
    if (2 * BORDER >= BUTTON_HEIGHT_Y || FLASH_FRAMES < 1) begin : g_bad_misc
        $error("menu_button_array: BORDER or FLASH_FRAMES out of range");
    end

    logic [2:0]  key_level_s;
    logic [2:0]  key_edge_s;
    menu_state_t state_r;
    logic [CW-1:0] cnt_r;

    assign key_level_s = {keyEnter, keyDown, keyUp};

    key_edge_detect #(.WIDTH(3)) u_keys (
        .clk    (clk),
        .resetN (resetN),
        .level  (key_level_s),
        .rise   (key_edge_s)
    );

    // Selection / flash FSM with registered selection and pressed pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r      <= NAV;
            cnt_r        <= '0;
            selectedIdx  <= '0;
            pressedValid <= 1'b0;
            pressedIdx   <= '0;
        end else begin
            pressedValid <= 1'b0;
            if (!enable) begin
                state_r <= NAV;
            end else begin
                case (state_r)
                    NAV: begin
                        if (key_edge_s[2]) begin
                            state_r <= FLASH;
                            cnt_r   <= '0;
                        end else if (key_edge_s[0] && !key_edge_s[1]) begin
                            selectedIdx <= (selectedIdx == '0) ? IW'(NUM_BUTTONS - 1)
                                                               : selectedIdx - IW'(1);
                        end else if (key_edge_s[1] && !key_edge_s[0]) begin
                            selectedIdx <= (selectedIdx == IW'(NUM_BUTTONS - 1)) ? '0
                                                               : selectedIdx + IW'(1);
                        end else begin
                            state_r <= NAV;
                        end
                    end
                    FLASH: begin
                        if (startOfFrame) begin
                            if (cnt_r == CW'(FLASH_FRAMES - 1)) begin
                                pressedValid <= 1'b1;
                                pressedIdx   <= selectedIdx;
                                state_r      <= NAV;
                            end else begin
                                cnt_r <= cnt_r + CW'(1);
                            end
                        end else begin
                            state_r <= FLASH;
                        end
                    end
                    default: state_r <= NAV;
                endcase
            end
        end
    end

    // Geometry is evaluated on 12 bits so the largest pixel coordinate cannot alias into a hit.
    logic [11:0]            x_s;
    logic [11:0]            y_s;
    logic                   in_x_s;
    logic [NUM_BUTTONS-1:0] hit_s;
    logic [10:0]            off_y_s [NUM_BUTTONS];

    assign x_s    = {1'b0, pixelX};
    assign y_s    = {1'b0, pixelY};
    assign in_x_s = in_span(x_s, 12'(ORIGIN_X), 12'(BUTTON_WIDTH_X));

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_hit
        localparam logic [11:0] TOP = 12'(ORIGIN_Y + i * PITCH);
        assign hit_s[i]   = in_x_s && in_span(y_s, TOP, 12'(BUTTON_HEIGHT_Y));
        assign off_y_s[i] = 11'(y_s - TOP);
    end

    logic [IW-1:0] hit_idx_s;
    logic          any_hit_s;
    logic [10:0]   off_x_s;
    logic [10:0]   off_y_sel_s;
    logic          border_s;
    logic [7:0]    colour_s;

    // Priority-encode the hit, then pick the fill colour for that pixel.
    always_comb begin
        hit_idx_s = '0;
        for (int k = NUM_BUTTONS - 1; k >= 0; k--) begin
            hit_idx_s = hit_s[k] ? IW'(k) : hit_idx_s;
        end
        any_hit_s   = |hit_s;
        off_x_s     = 11'(x_s - 12'(ORIGIN_X));
        off_y_sel_s = off_y_s[hit_idx_s];
        border_s    = (off_x_s < 11'(BORDER)) || (off_x_s >= 11'(BUTTON_WIDTH_X - BORDER)) ||
                      (off_y_sel_s < 11'(BORDER)) || (off_y_sel_s >= 11'(BUTTON_HEIGHT_Y - BORDER));
        if (border_s) begin
            colour_s = COLOR_BORDER;
        end else if (hit_idx_s == selectedIdx && state_r == FLASH) begin
            colour_s = cnt_r[0] ? COLOR_SLCT : COLOR_PRESS;
        end else if (hit_idx_s == selectedIdx) begin
            colour_s = COLOR_SLCT;
        end else begin
            colour_s = COLOR_REGU;
        end
    end

    // Register the drawing outputs; disabled or outside pixels present the transparent values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drawingRequest <= 1'b0;
            RGBout         <= TRANSPARENT_ENCODING;
            offsetX        <= '0;
            offsetY        <= '0;
            buttonIdx      <= '0;
        end else if (enable && any_hit_s) begin
            drawingRequest <= 1'b1;
            RGBout         <= colour_s;
            offsetX        <= off_x_s;
            offsetY        <= off_y_sel_s;
            buttonIdx      <= hit_idx_s;
        end else begin
            drawingRequest <= 1'b0;
            RGBout         <= TRANSPARENT_ENCODING;
            offsetX        <= '0;
            offsetY        <= '0;
            buttonIdx      <= '0;
        end
    end

endmodule

// File: tb/tb_menu_button_array.sv
// Scoreboard bench for menu_button_array: probes push expected outputs, a monitor pops and compares.
module tb_menu_button_array;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = 11'd0;
    logic [10:0] pixelY = 11'd0;
    logic        enable = 1'b0;
    logic        keyUp = 1'b0;
    logic        keyDown = 1'b0;
    logic        keyEnter = 1'b0;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [1:0]  buttonIdx;
    logic [1:0]  selectedIdx;
    logic        pressedValid;
    logic [1:0]  pressedIdx;

    menu_button_array dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .enable         (enable),
        .keyUp          (keyUp),
        .keyDown        (keyDown),
        .keyEnter       (keyEnter),
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .buttonIdx      (buttonIdx),
        .selectedIdx    (selectedIdx),
        .pressedValid   (pressedValid),
        .pressedIdx     (pressedIdx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        dr;
        logic [7:0]  rgb;
        logic [10:0] ox;
        logic [10:0] oy;
        logic [1:0]  idx;
        logic [1:0]  sel;
    } exp_t;

    exp_t       draw_q[$];
    logic [1:0] press_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         probe_id = 0;
    logic       probe = 1'b0;
    logic       probe_d = 1'b0;

    // A probe driven before a clock edge is answered by the registered outputs after that edge.
    always @(posedge clk) probe_d <= probe;

    always @(negedge clk) begin
        exp_t e;
        logic [1:0] pi;
        if (probe_d) begin
            n_checks++;
            if (draw_q.size() == 0) begin
                $display("FAIL probe_underflow: got an output probe with no expectation queued");
            end else begin
                e = draw_q.pop_front();
                if (drawingRequest === e.dr && RGBout === e.rgb && offsetX === e.ox &&
                    offsetY === e.oy && buttonIdx === e.idx && selectedIdx === e.sel) begin
                    n_pass++;
                end else begin
                    $display("FAIL probe%0d: got dr=%0d rgb=%h ox=%0d oy=%0d idx=%0d sel=%0d, want dr=%0d rgb=%h ox=%0d oy=%0d idx=%0d sel=%0d",
                             e.id, drawingRequest, RGBout, offsetX, offsetY, buttonIdx, selectedIdx,
                             e.dr, e.rgb, e.ox, e.oy, e.idx, e.sel);
                end
            end
        end
        if (pressedValid === 1'b1) begin
            n_checks++;
            if (press_q.size() == 0) begin
                $display("FAIL unexpected_press: got pressedValid idx=%0d, want no pulse", pressedIdx);
            end else begin
                pi = press_q.pop_front();
                if (pressedIdx === pi) begin
                    n_pass++;
                end else begin
                    $display("FAIL press_idx: got %0d, want %0d", pressedIdx, pi);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic probe_px(input int x, input int y, input logic dr, input logic [7:0] rgb,
                            input int ox, input int oy, input int idx, input int sel);
        exp_t e;
        pixelX = 11'(x);
        pixelY = 11'(y);
        e.id  = probe_id;
        e.dr  = dr;
        e.rgb = rgb;
        e.ox  = 11'(ox);
        e.oy  = 11'(oy);
        e.idx = 2'(idx);
        e.sel = 2'(sel);
        probe_id++;
        draw_q.push_back(e);
        probe = 1'b1;
        step();
        probe = 1'b0;
    endtask

    task automatic probe_out(input int sel);
        probe_px(0, 0, 1'b0, 8'hFF, 0, 0, 0, sel);
    endtask

    task automatic key(input logic u, input logic d, input logic e);
        keyUp = u; keyDown = d; keyEnter = e;
        step();
        step();
        keyUp = 1'b0; keyDown = 1'b0; keyEnter = 1'b0;
        step();
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
    endtask

    initial begin
        step();
        step();
        probe_px(300, 130, 1'b0, 8'hFF, 0, 0, 0, 0);
        resetN = 1'b1;
        enable = 1'b1;
        step();

        // Geometry and colours with button 0 selected.
        probe_px(300, 130, 1'b1, 8'h10, 40, 30, 0, 0);
        probe_px(300, 155, 1'b0, 8'hFF, 0, 0, 0, 0);
        probe_px(260, 100, 1'b1, 8'h00, 0, 0, 0, 0);
        probe_px(300, 180, 1'b1, 8'h80, 40, 20, 1, 0);
        probe_px(379, 329, 1'b1, 8'h00, 119, 49, 3, 0);
        probe_px(380, 300, 1'b0, 8'hFF, 0, 0, 0, 0);
        probe_px(300, 330, 1'b0, 8'hFF, 0, 0, 0, 0);
        probe_px(2047, 130, 1'b0, 8'hFF, 0, 0, 0, 0);

        // Navigation with wrap-around and simultaneous keys.
        key(1'b1, 1'b0, 1'b0);
        probe_px(300, 300, 1'b1, 8'h10, 40, 20, 3, 3);
        key(1'b0, 1'b1, 1'b0);
        probe_out(0);
        key(1'b1, 1'b1, 1'b0);
        probe_out(0);

        keyDown = 1'b1;
        repeat (100) step();
        keyDown = 1'b0;
        step();
        probe_out(1);
        key(1'b0, 1'b1, 1'b0);
        probe_out(2);

        // Full press flash on button 2, Up ignored midway.
        key(1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 8; f++) begin
            probe_px(300, 240, 1'b1, (f % 2 == 0) ? 8'hFC : 8'h10, 40, 20, 2, 2);
            if (f == 3) key(1'b1, 1'b0, 1'b0);
            if (f == 7) press_q.push_back(2'd2);
            frame();
        end
        probe_px(300, 240, 1'b1, 8'h10, 40, 20, 2, 2);

        // Flash aborted by disable: no pulse, selection held, back in navigation.
        key(1'b0, 1'b0, 1'b1);
        repeat (3) frame();
        enable = 1'b0;
        step();
        probe_px(300, 240, 1'b0, 8'hFF, 0, 0, 0, 2);
        repeat (8) frame();
        enable = 1'b1;
        step();
        key(1'b0, 1'b1, 1'b0);
        probe_px(300, 300, 1'b1, 8'h10, 40, 20, 3, 3);

        // Reset in the middle of a flash.
        key(1'b0, 1'b0, 1'b1);
        frame();
        frame();
        resetN = 1'b0;
        step();
        probe_px(300, 130, 1'b0, 8'hFF, 0, 0, 0, 0);
        resetN = 1'b1;
        step();
        repeat (10) frame();
        probe_px(300, 130, 1'b1, 8'h10, 40, 30, 0, 0);

        repeat (3) step();
        while (press_q.size() > 0) begin
            n_checks++;
            $display("FAIL missing_press: got no pressedValid, want idx=%0d", press_q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
